// File: rtl/sar_adc_seq.sv
// rtl/sar_adc_seq.sv - SAR ADC controller with channel-mask scan sequencer
// Drives the analog macro (mux, sample switch, DAC) and presents tagged results.
module sar_adc_seq #(
  parameter int WIDTH         = 8,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 2,
  localparam int CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp_sel,
  input  logic             cmp_int,
  input  logic             cmp_ext,
  input  logic             ack,
  output logic [CHW-1:0]   ch_sel,
  output logic             sample,
  output logic [WIDTH-1:0] dac,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic [CHW-1:0]   data_ch,
  output logic             data_valid,
  output logic             overrun
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, STORE} state_t;

  state_t           state;
  logic [NCH-1:0]   mask_q;
  logic [7:0]       cnt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] acc;
  logic             cmp;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] trial;
  logic [CHW-1:0]   first_ch;
  logic [CHW-1:0]   next_ch;
  logic             wrap;

  assign cmp = cmp_sel ? cmp_ext : cmp_int;

  // dac already holds result_so_far | bit k, so the decision only clears bit k
  always_comb begin
    bit_k = WIDTH'(1) << k;
    trial = cmp ? dac : (dac & ~bit_k);
  end

  always_comb begin
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (ch_mask[i]) first_ch = CHW'(i);
    next_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask_q[i]) next_ch = CHW'(i);
    wrap = 1'b1;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask_q[i] && (CHW'(i) > ch_sel)) begin
        next_ch = CHW'(i);
        wrap    = 1'b0;
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask_q     <= '0;
      cnt        <= '0;
      k          <= '0;
      acc        <= '0;
      ch_sel     <= '0;
      sample     <= 1'b0;
      dac        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ack) data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (|ch_mask)) begin
            mask_q <= ch_mask;
            ch_sel <= first_ch;
            cnt    <= '0;
            sample <= 1'b1;
            busy   <= 1'b1;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (cnt == 8'(SAMPLE_CYCLES - 1)) begin
            sample <= 1'b0;
            dac    <= WIDTH'(1) << (WIDTH - 1);
            k      <= KW'(WIDTH - 1);
            state  <= CONV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CONV: begin
          if (k == '0) begin
            acc   <= trial;
            dac   <= '0;
            state <= STORE;
          end else begin
            dac <= trial | (bit_k >> 1);
            k   <= k - 1'b1;
          end
        end
        STORE: begin
          done       <= 1'b1;
          data       <= acc;
          data_ch    <= ch_sel;
          data_valid <= 1'b1;
          if (data_valid && !ack) overrun <= 1'b1;
          // cont is read live here so clearing it ends the scan after this pass
          if (wrap && !cont) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ch_sel <= next_ch;
            cnt    <= '0;
            sample <= 1'b1;
            state  <= SAMPLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
- Parametrised SAR ADC controller and channel sequencer; next generation of the 8-bit single-channel SAR controller.
- Generalised in resolution (WIDTH) and analog channel count (NCH), with a programmable sample phase.
- Adds single-shot and continuous scan modes over a channel mask, a tagged result register with valid/ack handshake, and a sticky overrun flag.
- Sits between the digital control bus and the analog macro (comparator, DAC, input mux, sample switch); comparator source is selectable internal/external.

Parameters:
- WIDTH, 8, conversion resolution in bits (2..16).
- NCH, 4, number of analog input channels (1..16).
- SAMPLE_CYCLES, 2, cycles the sample switch is closed before conversion (1..255).
- CHW, $clog2(NCH) (minimum 1), width of the channel index; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  conversion/scan request, level-sampled each cycle.
- cont  in  1  1 = continuous scan, 0 = single pass over the mask.
- ch_mask  in  NCH  enabled channels; latched on an accepted start.
- cmp_sel  in  1  0 = internal comparator, 1 = external comparator.
- cmp_int  in  1  internal comparator output (1 = input >= DAC level).
- cmp_ext  in  1  external comparator output, same polarity.
- ack  in  1  consumer acknowledge; clears data_valid.
- ch_sel  out  CHW  analog mux select.
- sample  out  1  sample-switch enable.
- dac  out  WIDTH  DAC trial code.
- busy  out  1  controller not in IDLE.
- done  out  1  one-cycle pulse per completed conversion.
- data  out  WIDTH  last conversion result.
- data_ch  out  CHW  channel of data.
- data_valid  out  1  unread result present.
- overrun  out  1  sticky: a result was overwritten while unread.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched mask 0.
- cmp = cmp_sel ? cmp_ext : cmp_int, used combinationally and registered only at SAR decision edges.
- FSM states: IDLE, SAMPLE, CONV, STORE.
- IDLE: start=1 and ch_mask!=0 -> latch mask and cont, set ch_sel to the lowest set mask bit, go to SAMPLE. start with ch_mask=0 is ignored (stay IDLE, no flags).
- SAMPLE: sample=1 and dac=0 for exactly SAMPLE_CYCLES cycles, then CONV with bit index k=WIDTH-1.
- CONV, one cycle per bit, MSB first:
  - dac = result_so_far | (1<<k).
  - At the ending clock edge, bit k is kept if cmp=1, else cleared; then k decrements.
  - After k=0, go to STORE. Total WIDTH cycles.
- STORE, one cycle:
  - done=1; data and data_ch updated; data_valid=1.
  - overrun is set if data_valid was already 1 and ack is not asserted this cycle.
  - Next channel = next higher set bit of the latched mask, wrapping to the lowest.
  - If that wrap completes the pass and cont=0, go to IDLE.
  - Otherwise set ch_sel to the next channel and go to SAMPLE.
- cont is re-sampled in STORE. Deasserting it mid-scan stops at the end of the current pass.
- Latency: start sampled at edge 0 -> done high after edge 1+SAMPLE_CYCLES+WIDTH, for one cycle.
- data_valid cleared by ack=1 in any cycle. Simultaneous STORE and ack: the new result wins (data_valid=1, no overrun).
- overrun cleared only by rst.
- start while busy is ignored. ch_mask changes while busy have no effect.
- Single-bit mask with cont=1: converts the same channel back-to-back, with no IDLE cycle between.
- busy is 0 only in IDLE; dac=0 and sample=0 in IDLE.
- rst mid-operation: immediate return to IDLE with all outputs 0; a partial result is discarded.

Test Plan:
- WIDTH=8, NCH=4, SAMPLE_CYCLES=2; comparator model cmp_int = (vin >= dac), vin=0xA5, mask=4'b0001, cont=0, pulse start -> done at edge 11 after start, data=0xA5, data_ch=0, busy drops the next cycle.
- Boundaries: vin=0x00 -> data=0x00; vin=0xFF -> data=0xFF. Also check the dac trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 for vin=0xA5.
- mask=4'b1010, cont=0, per-channel vin {ch1=0x10, ch3=0xF0}, ack after each done -> results ch1=0x10 then ch3=0xF0, then IDLE. No conversion on channels 0 or 2; overrun=0.
- Overrun and ack: mask=4'b0100, cont=1, no ack -> overrun=1 at the second done. Deassert cont -> stops after the current pass. Ack in the same cycle as a STORE -> data_valid stays 1.
- cmp_sel=1, cmp_ext tied 1, cmp_int tied 0 -> data=all ones. Also: start with ch_mask=0 -> busy stays 0.
- Assert rst during CONV bit 4 -> all outputs 0 the same cycle. A new start after release gives a correct full conversion.
